// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin arbiter for port 0 (ifetch) and port 1 (LSU) in front of single-port memory.
// Latency: accept in cycle C, memory command in C+1, response pulse one cycle after mem_done.
// Backpressure: reqN_ready pulses only in IDLE; requestors hold valid and fields until accepted.
// Optional build macro MEM_ARB_TIMEOUT_EN: bounded WAIT that answers with err=1, data 0xDEADBEEF.

module mem_req_arbiter #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  resp0_valid,
    output logic [DATA_WIDTH-1:0] resp0_data,
    output logic                  resp0_err,

    input  logic                  req1_valid,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  resp1_valid,
    output logic [DATA_WIDTH-1:0] resp1_data,
    output logic                  resp1_err,

    output logic                  mem_en,
    output logic                  mem_re,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // Last granted port; it is also the owner of the request in flight.
    logic                  r_last_grant;
    logic                  r_owner_wr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic                  r_resp0_valid;
    logic                  r_resp1_valid;
    logic [DATA_WIDTH-1:0] r_resp0_data;
    logic [DATA_WIDTH-1:0] r_resp1_data;

    logic                  w_grant_vld;
    logic                  w_grant_port;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_timeout;
    logic                  w_finish;
    logic                  w_req0_ready;
    logic                  w_req1_ready;
    logic                  w_mem_en;
    logic                  w_mem_re;
    logic                  w_mem_wr;
    logic [DATA_WIDTH-1:0] w_resp_data;

    // TIMEOUT must leave room for at least one WAIT cycle
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_req_arbiter: TIMEOUT must be >= 1");
    end

    // Grant choice: the lone valid port, or on a tie the port not granted last
    always_comb begin
        w_grant_vld  = req0_valid | req1_valid;
        w_grant_port = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_port = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant_port = 1'b1;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_resp0_err;
    logic             r_resp1_err;

    // WAIT-cycle counter, held at zero outside WAIT so each WAIT entry starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state != ST_WAIT) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != CNT_LAST) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    // Give up on the memory after TIMEOUT WAIT cycles; a done in the same cycle wins
    assign w_timeout = (r_state == ST_WAIT) && !mem_done && (r_wait_cnt == CNT_LAST);

    // Error flag rides only on a timeout response pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp0_err <= 1'b0;
            r_resp1_err <= 1'b0;
        end else begin
            r_resp0_err <= w_timeout && !r_last_grant;
            r_resp1_err <= w_timeout &&  r_last_grant;
        end
    end

    assign resp0_err = r_resp0_err;
    assign resp1_err = r_resp1_err;
`else
    assign w_timeout = 1'b0;
    assign resp0_err = 1'b0;
    assign resp1_err = 1'b0;
`endif

    // Next state plus per-state handshake and memory command decode
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        w_mem_en     = 1'b0;
        w_mem_re     = 1'b0;
        w_mem_wr     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    w_accept     = 1'b1;
                    w_req0_ready = ~w_grant_port;
                    w_req1_ready =  w_grant_port;
                    w_state_nxt  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_mem_en    = 1'b1;
                w_mem_wr    =  r_owner_wr;
                w_mem_re    = ~r_owner_wr;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_done) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_finish = w_done | w_timeout;

    // Response payload: read data, zero for writes, marker word on timeout
    always_comb begin
        w_resp_data = '0;
        if (w_timeout) begin
            w_resp_data = DATA_WIDTH'(32'hDEADBEEF);
        end else if (!r_owner_wr) begin
            w_resp_data = mem_rdata;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the granted request; it stays on the memory bus until the next grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_owner_wr   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_grant_port;
            r_owner_wr   <= w_grant_port ? req1_wr    : req0_wr;
            r_mem_addr   <= w_grant_port ? req1_addr  : req0_addr;
            r_mem_wdata  <= w_grant_port ? req1_wdata : req0_wdata;
        end
    end

    // One-cycle response pulses steered to the owner of the finished request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp0_data  <= '0;
            r_resp1_data  <= '0;
        end else begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            if (w_finish) begin
                if (r_last_grant) begin
                    r_resp1_valid <= 1'b1;
                    r_resp1_data  <= w_resp_data;
                end else begin
                    r_resp0_valid <= 1'b1;
                    r_resp0_data  <= w_resp_data;
                end
            end
        end
    end

    // Ready is suppressed while reset is asserted even though IDLE decodes a grant
    assign req0_ready  = w_req0_ready & ~rst;
    assign req1_ready  = w_req1_ready & ~rst;

    assign mem_en      = w_mem_en;
    assign mem_re      = w_mem_re;
    assign mem_wr      = w_mem_wr;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;

    assign resp0_valid = r_resp0_valid;
    assign resp0_data  = r_resp0_data;
    assign resp1_valid = r_resp1_valid;
    assign resp1_data  = r_resp1_data;

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Two-requestor arbiter directly upstream of the single-port main memory.
- Port 0 serves instruction fetch; port 1 serves the LSU.
- Grants one request at a time round-robin, drives a one-cycle memory command, waits for mem_done, returns a one-cycle response to the owning port.
- The memory serves one request at a time, so this block is its only master.

Parameters:
- ADDR_WIDTH, 20, byte address width; matches memory.
- DATA_WIDTH, 32, request/response data width.
- TIMEOUT, 64, WAIT-state cycle limit; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- req0_valid  input  1  port 0 request; held until req0_ready
- req0_wr  input  1  1 = write, 0 = read
- req0_addr  input  ADDR_WIDTH  byte address
- req0_wdata  input  DATA_WIDTH  write data
- req0_ready  output  1  one-cycle accept pulse
- resp0_valid  output  1  one-cycle completion pulse
- resp0_data  output  DATA_WIDTH  read data; 0 for writes
- resp0_err  output  1  timeout flag, qualified by resp0_valid
- req1_valid, req1_wr, req1_addr, req1_wdata, req1_ready, resp1_valid, resp1_data, resp1_err: same as port 0
- mem_en  output  1  memory enable
- mem_re  output  1  memory read command
- mem_wr  output  1  memory write command
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_rdata  input  DATA_WIDTH  memory read data, valid with mem_done
- mem_done  input  1  memory completion pulse

Behaviour:
- Clocking: single clock clk; rst asynchronous, active-high.
- Reset state:
  - State machine to IDLE; last_grant = 1, so port 0 wins the first tie.
  - All registered outputs = 0: mem_addr, mem_wdata, respN_valid, respN_data, respN_err.
  - mem_en/mem_re/mem_wr = 0; reqN_ready forced 0 while rst is high.
- State machine (IDLE, ISSUE, WAIT):
  - IDLE: grant = the valid port; if both are valid, the port != last_grant.
    - reqN_ready = 1 combinationally for the granted port, this cycle only.
    - At the edge, latch wr/addr/wdata into mem_addr/mem_wdata and an owner register; set last_grant; go to ISSUE.
  - ISSUE: mem_en = 1, with mem_wr = owner_wr and mem_re = !owner_wr, for exactly one cycle; then go to WAIT.
  - WAIT: mem_en/re/wr = 0. On mem_done = 1:
    - next edge: respN_valid = 1 for the owner; respN_data = mem_rdata for a read, 0 for a write; respN_err = 0; go to IDLE.
- Response pulses: respN_valid clears after one cycle. A resp pulse and a new grant may occur in the same cycle.
- Latency:
  - Accept cycle C.
  - Memory command in C+1.
  - With memory LATENCY = L, mem_done is visible in C+L+2 and resp is visible in C+L+3.
- mem_done handling: ignored in IDLE and ISSUE; must not produce a response.
- Request inputs: not sampled outside IDLE; a requestor holds valid and fields stable until ready.
- Back-to-back from the same port: allowed. With the other port idle, the same port is re-granted.
- Reset mid-operation: in-flight request discarded and no response issued; requestors re-present after reset.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A WAIT-state counter, cleared on entry to WAIT, increments each WAIT cycle.
  - When it reaches TIMEOUT without mem_done: owner gets respN_valid = 1, respN_err = 1, respN_data = 32'hDEADBEEF; go to IDLE.
  - A late mem_done is then ignored per the IDLE/ISSUE rule.
- Undefined: no counter; WAIT waits indefinitely; respN_err tied to 0.

Test Plan:
- Memory L = 10; write port1 addr 0x00010, data 0xA5 in cycle 0 -> req1_ready in cycle 0, mem_en & mem_wr in cycle 1, resp1_valid in cycle 13 with resp1_data = 0.
- Read port0 addr 0x00010 after the above write -> resp0_valid pulse with resp0_data = 0xA5 exactly 13 cycles after accept; resp1_valid stays 0.
- Both ports valid after reset -> port 0 granted first, port 1 granted in the cycle port 0's response pulses; alternation continues over 4 back-to-back requests (0,1,0,1).
- rst asserted 5 cycles into WAIT -> all outputs 0 immediately; no resp pulse for the lost request; a new port1 read after release completes normally.
- Spurious mem_done pulse in IDLE -> no resp0_valid/resp1_valid.
- MEM_ARB_TIMEOUT_EN, TIMEOUT = 8, mem_done held 0 -> owner resp pulse with err = 1, data 0xDEADBEEF, 8 cycles after WAIT entry.
